gfx128_clip_plot: RTL and testbench

Per-pixel clip-and-plot stage that sits directly downstream of the text blitter. It accepts one pixel request at a time (coordinate plus plot flag) and tests the pixel against an inclusive clip rectangle. For visible pixels it computes the 128-bit-aligned framebuffer address, byte-lane select and replicated colour, then issues a single masked memory write. Every request is acknowledged exactly once, so the upstream pixel walker can advance.

---
 rtl/gfx128_clip_plot_if.sv | 32 +++
 rtl/gfx128_clip_plot.sv | 84 ++++++++
 tb/tb_gfx128_clip_plot.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/gfx128_clip_plot_if.sv
// gfx128_clip_plot_if: pixel request, clip/target configuration and 128-bit memory write bus
interface gfx128_clip_plot_if #(parameter int point_width = 16);
   logic                   stb_i;
   logic                   wr_i;
   logic [point_width-1:0] x_i;
   logic [point_width-1:0] y_i;
   logic                   clip_en_i;
   logic [point_width-1:0] clip_ul_x_i;
   logic [point_width-1:0] clip_ul_y_i;
   logic [point_width-1:0] clip_lr_x_i;
   logic [point_width-1:0] clip_lr_y_i;
   logic [31:0]            target_base_i;
   logic [15:0]            target_width_i;
   logic [1:0]             color_depth_i;
   logic [31:0]            color_i;
   logic                   ack_o;
   logic                   write_request_o;
   logic                   mem_ack_i;
   logic [31:0]            mem_adr_o;
   logic [15:0]            mem_sel_o;
   logic [127:0]           mem_dat_o;
   modport slave (
      input  stb_i, wr_i, x_i, y_i, clip_en_i, clip_ul_x_i, clip_ul_y_i, clip_lr_x_i, clip_lr_y_i,
      input  target_base_i, target_width_i, color_depth_i, color_i, mem_ack_i,
      output ack_o, write_request_o, mem_adr_o, mem_sel_o, mem_dat_o
   );
   modport master (
      output stb_i, wr_i, x_i, y_i, clip_en_i, clip_ul_x_i, clip_ul_y_i, clip_lr_x_i, clip_lr_y_i,
      output target_base_i, target_width_i, color_depth_i, color_i, mem_ack_i,
      input  ack_o, write_request_o, mem_adr_o, mem_sel_o, mem_dat_o
   );
endinterface

// File: rtl/gfx128_clip_plot.sv
// gfx128_clip_plot: clips one pixel per request and issues a masked 128-bit framebuffer write
module gfx128_clip_plot #(parameter int point_width = 16) (
   input logic               clk_i,
   input logic               rst_i,
   gfx128_clip_plot_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MUL, ADR, WRITE} state_t;
   state_t                 r_state, w_next;
   logic [point_width-1:0] r_x, r_y;
   logic [31:0]            r_color, r_pix_off, r_adr;
   logic [1:0]             r_depth;
   logic                   r_ack, r_req;
   logic [15:0]            r_sel;
   logic [127:0]           r_dat;
   logic                   w_vis, w_done;
   logic [31:0]            w_mul, w_a;
   logic [3:0]             w_lane;
   logic [15:0]            w_sel;
   logic [127:0]           w_dat;
   assign w_vis = bus.wr_i & (~bus.clip_en_i |
                  (bus.clip_ul_x_i <= bus.x_i && bus.x_i <= bus.clip_lr_x_i &&
                   bus.clip_ul_y_i <= bus.y_i && bus.y_i <= bus.clip_lr_y_i));
   assign w_done = (r_state == WRITE) && bus.mem_ack_i;
   assign w_mul  = 32'(r_y) * 32'(bus.target_width_i) + 32'(r_x);
   // depth 3 falls through to the 32bpp arm
   assign w_a    = bus.target_base_i + (r_depth == 2'd0 ? r_pix_off :
                   r_depth == 2'd1 ? {r_pix_off[30:0], 1'b0} : {r_pix_off[29:0], 2'b00});
   assign w_lane = w_a[3:0];
   assign w_sel  = r_depth == 2'd0 ? 16'h0001 << w_lane :
                   r_depth == 2'd1 ? 16'h0003 << {w_lane[3:1], 1'b0} :
                                     16'h000F << {w_lane[3:2], 2'b00};
   assign w_dat  = r_depth == 2'd0 ? {16{r_color[7:0]}} :
                   r_depth == 2'd1 ? {8{r_color[15:0]}} : {4{r_color}};
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = (bus.stb_i && w_vis) ? MUL : IDLE;
         MUL:     w_next = ADR;
         ADR:     w_next = WRITE;
         WRITE:   w_next = bus.mem_ack_i ? IDLE : WRITE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_next;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_x       <= '0;
         r_y       <= '0;
         r_color   <= '0;
         r_depth   <= '0;
         r_pix_off <= '0;
         r_ack     <= 1'b0;
         r_req     <= 1'b0;
         r_adr     <= '0;
         r_sel     <= '0;
         r_dat     <= '0;
      end else begin
         r_ack <= ((r_state == IDLE) && bus.stb_i && !w_vis) || w_done;
         if (r_state == IDLE && bus.stb_i) begin
            r_x     <= bus.x_i;
            r_y     <= bus.y_i;
            r_color <= bus.color_i;
            r_depth <= bus.color_depth_i;
         end
         if (r_state == MUL) r_pix_off <= w_mul;
         if (r_state == ADR) begin
            r_req <= 1'b1;
            r_adr <= {w_a[31:4], 4'b0000};
            r_sel <= w_sel;
            r_dat <= w_dat;
         end else if (w_done) begin
            r_req <= 1'b0;
         end
      end
   end
   assign bus.ack_o           = r_ack;
   assign bus.write_request_o = r_req;
   assign bus.mem_adr_o       = r_adr;
   assign bus.mem_sel_o       = r_sel;
   assign bus.mem_dat_o       = r_dat;
endmodule

// File: tb/tb_gfx128_clip_plot.sv
// tb_gfx128_clip_plot: directed and random pixels checked against an arithmetic address/mask model
module tb_gfx128_clip_plot;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   always #5 clk = ~clk;
   gfx128_clip_plot_if #(.point_width(16)) bus();
   gfx128_clip_plot #(.point_width(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic cfg(input bit clip, input int ulx, input int uly, input int lrx, input int lry,
                      input logic [31:0] base, input logic [15:0] width, input logic [1:0] depth,
                      input logic [31:0] color);
      bus.clip_en_i      = clip;
      bus.clip_ul_x_i    = 16'(ulx);
      bus.clip_ul_y_i    = 16'(uly);
      bus.clip_lr_x_i    = 16'(lrx);
      bus.clip_lr_y_i    = 16'(lry);
      bus.target_base_i  = base;
      bus.target_width_i = width;
      bus.color_depth_i  = depth;
      bus.color_i        = color;
   endtask
   // Called right after a falling edge; strobes in the following cycle N.
   task automatic pixel(input int x, input int y, input bit wr, input int delay, input bit stray,
                        input bit rst_mid);
      bit           vis;
      int           bpp, lane, start;
      longint       addr;
      logic [31:0]  ea;
      logic [15:0]  es;
      logic [127:0] ed;
      vis = wr && (!bus.clip_en_i ||
            (int'(bus.clip_ul_x_i) <= x && x <= int'(bus.clip_lr_x_i) &&
             int'(bus.clip_ul_y_i) <= y && y <= int'(bus.clip_lr_y_i)));
      bpp   = bus.color_depth_i == 2'd0 ? 1 : bus.color_depth_i == 2'd1 ? 2 : 4;
      addr  = (longint'(bus.target_base_i) +
              (longint'(y) * longint'(bus.target_width_i) + longint'(x)) * bpp) % 64'h1_0000_0000;
      ea    = 32'(addr - addr % 16);
      lane  = int'(addr % 16);
      start = lane - lane % bpp;
      es    = 16'(((1 << bpp) - 1) << start);
      for (int b = 0; b < 16; b++) ed[b*8 +: 8] = bus.color_i[(b % bpp)*8 +: 8];
      bus.x_i   = 16'(x);
      bus.y_i   = 16'(y);
      bus.wr_i  = wr;
      bus.stb_i = 1'b1;
      @(negedge clk);
      bus.stb_i = 1'b0;
      if (!vis) begin
         chk("skip_ack", bus.ack_o, 1);
         chk("skip_req", bus.write_request_o, 0);
         @(negedge clk);
         chk("skip_ack_low", bus.ack_o, 0);
         chk("skip_req_low", bus.write_request_o, 0);
         return;
      end
      chk("mul_ack", bus.ack_o, 0);
      chk("mul_req", bus.write_request_o, 0);
      @(negedge clk);
      chk("adr_req", bus.write_request_o, 0);
      @(negedge clk);
      chk("wr_req", bus.write_request_o, 1);
      chk("wr_adr", bus.mem_adr_o, ea);
      chk("wr_sel", bus.mem_sel_o, es);
      chk("wr_dat", bus.mem_dat_o, ed);
      chk("wr_ack", bus.ack_o, 0);
      if (rst_mid) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         chk("rst_req", bus.write_request_o, 0);
         chk("rst_ack", bus.ack_o, 0);
         chk("rst_adr", bus.mem_adr_o, 0);
         chk("rst_sel", bus.mem_sel_o, 0);
         chk("rst_dat", bus.mem_dat_o, 0);
         @(negedge clk);
         chk("rst_ack_after", bus.ack_o, 0);
         chk("rst_req_after", bus.write_request_o, 0);
         return;
      end
      for (int d = 0; d < delay; d++) begin
         bus.stb_i = stray && d == 0;
         @(negedge clk);
         bus.stb_i = 1'b0;
         chk("hold_req", bus.write_request_o, 1);
         chk("hold_adr", bus.mem_adr_o, ea);
         chk("hold_sel", bus.mem_sel_o, es);
         chk("hold_dat", bus.mem_dat_o, ed);
         chk("hold_ack", bus.ack_o, 0);
      end
      bus.mem_ack_i = 1'b1;
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      chk("done_ack", bus.ack_o, 1);
      chk("done_req", bus.write_request_o, 0);
      @(negedge clk);
      chk("done_ack_low", bus.ack_o, 0);
      chk("done_req_low", bus.write_request_o, 0);
   endtask
   initial begin
      bus.stb_i     = 1'b0;
      bus.wr_i      = 1'b0;
      bus.x_i       = '0;
      bus.y_i       = '0;
      bus.mem_ack_i = 1'b0;
      cfg(0, 0, 0, 0, 0, 32'h0, 16'd0, 2'd0, 32'h0);
      repeat (3) @(negedge clk);
      chk("reset_ack", bus.ack_o, 0);
      chk("reset_req", bus.write_request_o, 0);
      chk("reset_adr", bus.mem_adr_o, 0);
      chk("reset_sel", bus.mem_sel_o, 0);
      chk("reset_dat", bus.mem_dat_o, 0);
      rst = 1'b0;
      @(negedge clk);
      cfg(0, 0, 0, 0, 0, 32'h1000, 16'd640, 2'd0, 32'hAB);
      pixel(3, 2, 1, 0, 0, 0);
      cfg(0, 0, 0, 0, 0, 32'h0, 16'd640, 2'd1, 32'h1234);
      pixel(5, 0, 1, 0, 0, 0);
      cfg(0, 0, 0, 0, 0, 32'h0, 16'd640, 2'd2, 32'hDEADBEEF);
      pixel(5, 0, 1, 1, 0, 0);
      cfg(1, 0, 0, 99, 49, 32'h2000, 16'd320, 2'd0, 32'h5A);
      pixel(100, 10, 1, 0, 0, 0);
      pixel(99, 49, 1, 2, 0, 0);
      pixel(0, 50, 1, 0, 0, 0);
      cfg(0, 0, 0, 0, 0, 32'h3007, 16'd100, 2'd3, 32'hCAFEF00D);
      pixel(7, 7, 0, 0, 0, 0);
      pixel(7, 7, 1, 5, 1, 0);
      pixel(9, 3, 1, 0, 0, 1);
      pixel(9, 3, 1, 1, 0, 0);
      for (int i = 0; i < 300; i++) begin
         int ulx, uly;
         ulx = int'($urandom_range(0, 200));
         uly = int'($urandom_range(0, 200));
         cfg(1'($urandom), ulx, uly, ulx + int'($urandom_range(0, 200)), uly + int'($urandom_range(0, 200)),
             $urandom, 16'($urandom), 2'($urandom), $urandom);
         pixel(int'($urandom_range(0, 450)), int'($urandom_range(0, 450)), $urandom_range(0, 3) != 0,
               int'($urandom_range(0, 4)), 1'($urandom), $urandom_range(0, 19) == 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
